// File: rtl/chdr_pkt_deframer_pkg.sv
// Shared CHDR definitions: packet types, header layout, bus-width legality and
// the deframer state encoding.
package chdr_pkt_deframer_pkg;

    typedef enum logic [2:0] {
        PktMgmt       = 3'd0,
        PktStrs       = 3'd1,
        PktStrc       = 3'd2,
        PktCtrl       = 3'd4,
        PktDataNoTs   = 3'd6,
        PktDataWithTs = 3'd7
    } pkt_type_t;

    typedef struct packed {
        logic [5:0]  vc;
        logic        eob;
        logic        eov;
        pkt_type_t   pkt_type;
        logic [4:0]  num_mdata;
        logic [15:0] seq_num;
        logic [15:0] length;
        logic [15:0] dst_epid;
    } chdr_header_t;

    // {has_ts, timestamp[63:0], header[63:0]}
    localparam int unsigned HdrEntryW = 129;

    typedef enum logic [1:0] {ST_HDR, ST_TS, ST_MDATA, ST_PYLD} deframer_state_t;

    function automatic bit chdr_w_legal(input int unsigned w);
        return (w == 64) || (w == 128) || (w == 256) || (w == 512);
    endfunction

endpackage

// File: rtl/chdr_hdr_reg.sv
// One-entry header register with valid/ready handshake; accepts a new entry in
// the same cycle the held one is taken.
module chdr_hdr_reg #(
    parameter int unsigned WIDTH = 129
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) data_q <= in_data;
        end
    end

endmodule

// File: rtl/chdr_pkt_deframer.sv
// Splits a CHDR packet stream into header/timestamp, metadata and payload streams.
// Optional beat-count length check enabled by defining CHDR_DEFRAMER_LEN_CHECK_EN.
module chdr_pkt_deframer
    import chdr_pkt_deframer_pkg::*;
#(
    parameter int unsigned CHDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHDR_W-1:0] s_chdr_tdata,
    input  logic              s_chdr_tlast,
    input  logic              s_chdr_tvalid,
    output logic              s_chdr_tready,
    output logic [128:0]      m_hdr_tdata,
    output logic              m_hdr_tvalid,
    input  logic              m_hdr_tready,
    output logic [CHDR_W-1:0] m_mdata_tdata,
    output logic              m_mdata_tlast,
    output logic              m_mdata_tvalid,
    input  logic              m_mdata_tready,
    output logic [CHDR_W-1:0] m_pyld_tdata,
    output logic              m_pyld_tlast,
    output logic              m_pyld_tvalid,
    input  logic              m_pyld_tready,
    output logic              err_length,
    output logic [15:0]       err_count
);

    if (!chdr_w_legal(CHDR_W)) begin : g_illegal_width
        $error("chdr_pkt_deframer: illegal CHDR_W %0d", CHDR_W);
    end

    deframer_state_t        state_q, state_d;
    chdr_header_t           hdr_q, hdr_d, beat_hdr;
    logic [6:0]             cnt_q, cnt_d;
    logic [63:0]            beat_ts;
    logic                   beat_has_ts, beat_acc, s_rdy;
    logic                   hdr_push, hdr_in_ready;
    logic [HdrEntryW-1:0]   hdr_push_data;

    assign beat_hdr    = chdr_header_t'(s_chdr_tdata[63:0]);
    assign beat_has_ts = (beat_hdr.pkt_type == PktDataWithTs);

    // Wide buses carry the timestamp in the header beat itself.
    if (CHDR_W > 64) begin : g_wide_ts
        assign beat_ts = beat_has_ts ? s_chdr_tdata[127:64] : 64'd0;
    end else begin : g_narrow_ts
        assign beat_ts = 64'd0;
    end

    assign s_rdy = (state_q == ST_HDR || state_q == ST_TS) ? hdr_in_ready :
                   (state_q == ST_MDATA) ? m_mdata_tready : m_pyld_tready;
    assign s_chdr_tready = s_rdy && rst_n;
    assign beat_acc      = s_chdr_tvalid && s_chdr_tready;

    assign m_mdata_tdata = s_chdr_tdata;
    assign m_pyld_tdata  = s_chdr_tdata;

    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        cnt_d          = cnt_q;
        hdr_push       = 1'b0;
        hdr_push_data  = {beat_has_ts, beat_ts, beat_hdr};
        m_mdata_tvalid = 1'b0;
        m_mdata_tlast  = 1'b0;
        m_pyld_tvalid  = 1'b0;
        m_pyld_tlast   = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                if (beat_acc) begin
                    hdr_d = beat_hdr;
                    if (CHDR_W == 64 && beat_has_ts && !s_chdr_tlast) begin
                        state_d = ST_TS;
                    end else begin
                        hdr_push = 1'b1;
                        if (s_chdr_tlast) begin
                            state_d = ST_HDR;
                        end else if (beat_hdr.num_mdata != 5'd0) begin
                            state_d = ST_MDATA;
                            cnt_d   = {2'b00, beat_hdr.num_mdata};
                        end else begin
                            state_d = ST_PYLD;
                        end
                    end
                end
            end
            ST_TS: begin
                hdr_push_data = {1'b1, s_chdr_tdata[63:0], hdr_q};
                if (beat_acc) begin
                    hdr_push = 1'b1;
                    if (s_chdr_tlast) begin
                        state_d = ST_HDR;
                    end else if (hdr_q.num_mdata != 5'd0) begin
                        state_d = ST_MDATA;
                        cnt_d   = {2'b00, hdr_q.num_mdata};
                    end else begin
                        state_d = ST_PYLD;
                    end
                end
            end
            ST_MDATA: begin
                m_mdata_tvalid = s_chdr_tvalid;
                m_mdata_tlast  = (cnt_q == 7'd1) || s_chdr_tlast;
                if (beat_acc) begin
                    cnt_d = cnt_q - 7'd1;
                    if (s_chdr_tlast)        state_d = ST_HDR;
                    else if (cnt_q == 7'd1)  state_d = ST_PYLD;
                end
            end
            ST_PYLD: begin
                m_pyld_tvalid = s_chdr_tvalid;
                m_pyld_tlast  = s_chdr_tlast;
                if (beat_acc && s_chdr_tlast) state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR;
            hdr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
        end
    end

    chdr_hdr_reg #(
        .WIDTH (HdrEntryW)
    ) u_hdr_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (hdr_push_data),
        .in_valid  (hdr_push),
        .in_ready  (hdr_in_ready),
        .out_data  (m_hdr_tdata),
        .out_valid (m_hdr_tvalid),
        .out_ready (m_hdr_tready)
    );

`ifdef CHDR_DEFRAMER_LEN_CHECK_EN
    localparam int unsigned BytesPerBeat = CHDR_W / 8;
    localparam int unsigned BeatShift    = $clog2(BytesPerBeat);

    logic [15:0] len_q, cur_len, err_count_q;
    logic [16:0] beats_q, beats_now, beats_exp;
    logic        len_bad, err_length_q;

    assign cur_len   = (state_q == ST_HDR) ? beat_hdr.length : len_q;
    assign beats_now = (state_q == ST_HDR) ? 17'd1 : beats_q + 17'd1;
    assign beats_exp = ({1'b0, cur_len} + 17'(BytesPerBeat - 1)) >> BeatShift;
    // A narrow timestamped packet ending on its header beat is always malformed.
    assign len_bad = beat_acc && s_chdr_tlast &&
                     ((beats_now != beats_exp) ||
                      (CHDR_W == 64 && state_q == ST_HDR && beat_has_ts));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            beats_q      <= '0;
            err_length_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            err_length_q <= len_bad;
            if (len_bad && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
            if (beat_acc) begin
                beats_q <= s_chdr_tlast ? 17'd0 : beats_now;
                if (state_q == ST_HDR) len_q <= beat_hdr.length;
            end
        end
    end

    assign err_length = err_length_q;
    assign err_count  = err_count_q;
`else
    assign err_length = 1'b0;
    assign err_count  = 16'd0;
`endif

endmodule

// File: tb/tb_chdr_pkt_deframer.sv
// Scoreboard bench for chdr_pkt_deframer: a 64-bit instance under random
// backpressure plus a 256-bit instance for in-beat timestamps.
module tb_chdr_pkt_deframer;

    localparam int unsigned W  = 64;
    localparam int unsigned W2 = 256;
`ifdef CHDR_DEFRAMER_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]  s_tdata = '0;
    logic          s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
    logic [128:0]  hdr_tdata;
    logic          hdr_tvalid, hdr_tready = 1'b1;
    logic [W-1:0]  md_tdata, py_tdata;
    logic          md_tlast, md_tvalid, md_tready = 1'b1;
    logic          py_tlast, py_tvalid, py_tready = 1'b1;
    logic          err_len;
    logic [15:0]   err_cnt;

    logic [W2-1:0] s2_tdata = '0;
    logic          s2_tlast = 1'b0, s2_tvalid = 1'b0, s2_tready;
    logic [128:0]  hdr2_tdata;
    logic          hdr2_tvalid, md2_tlast, md2_tvalid, py2_tlast, py2_tvalid;
    logic          one = 1'b1;
    logic [W2-1:0] md2_tdata, py2_tdata;
    logic          err2_len;
    logic [15:0]   err2_cnt;

    int total = 0;
    int bad = 0;
    int pkt_id = 0;
    int exp_errs = 0;
    int hdr_stall = 0;
    bit rand_bp = 1'b1;
    logic [511:0] exp_hdr[$], exp_md[$], exp_py[$], exp2_hdr[$], exp2_py[$];
    logic [63:0]  h, d;
    logic [W2-1:0] beat2, pl2;

    chdr_pkt_deframer #(.CHDR_W(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_chdr_tdata(s_tdata), .s_chdr_tlast(s_tlast), .s_chdr_tvalid(s_tvalid),
        .s_chdr_tready(s_tready),
        .m_hdr_tdata(hdr_tdata), .m_hdr_tvalid(hdr_tvalid), .m_hdr_tready(hdr_tready),
        .m_mdata_tdata(md_tdata), .m_mdata_tlast(md_tlast), .m_mdata_tvalid(md_tvalid),
        .m_mdata_tready(md_tready),
        .m_pyld_tdata(py_tdata), .m_pyld_tlast(py_tlast), .m_pyld_tvalid(py_tvalid),
        .m_pyld_tready(py_tready),
        .err_length(err_len), .err_count(err_cnt)
    );

    chdr_pkt_deframer #(.CHDR_W(W2)) u_dut_w256 (
        .clk(clk), .rst_n(rst_n),
        .s_chdr_tdata(s2_tdata), .s_chdr_tlast(s2_tlast), .s_chdr_tvalid(s2_tvalid),
        .s_chdr_tready(s2_tready),
        .m_hdr_tdata(hdr2_tdata), .m_hdr_tvalid(hdr2_tvalid), .m_hdr_tready(one),
        .m_mdata_tdata(md2_tdata), .m_mdata_tlast(md2_tlast), .m_mdata_tvalid(md2_tvalid),
        .m_mdata_tready(one),
        .m_pyld_tdata(py2_tdata), .m_pyld_tlast(py2_tlast), .m_pyld_tvalid(py2_tvalid),
        .m_pyld_tready(one),
        .err_length(err2_len), .err_count(err2_cnt)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [2:0] pt, input logic [4:0] nm,
                                           input logic [15:0] len, input logic [15:0] seq);
        return {6'd0, 1'b0, 1'b0, pt, nm, seq, len, 16'h0042};
    endfunction

    // Output sinks: random backpressure on mdata/payload, scripted header stall.
    always @(posedge clk) begin
        #1;
        md_tready = !rand_bp || ($urandom_range(3) != 0);
        py_tready = !rand_bp || ($urandom_range(3) != 0);
        if (hdr_stall > 0) hdr_stall--;
        hdr_tready = (hdr_stall == 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (hdr_tvalid && hdr_tready) begin
                if (exp_hdr.size() == 0) check_eq("hdr_unexpected", exp_hdr.size(), 1);
                else check_eq("hdr", hdr_tdata, exp_hdr.pop_front());
            end
            if (md_tvalid && md_tready) begin
                if (exp_md.size() == 0) check_eq("mdata_unexpected", exp_md.size(), 1);
                else check_eq("mdata", {md_tlast, md_tdata}, exp_md.pop_front());
            end
            if (py_tvalid && py_tready) begin
                if (exp_py.size() == 0) check_eq("pyld_unexpected", exp_py.size(), 1);
                else check_eq("pyld", {py_tlast, py_tdata}, exp_py.pop_front());
            end
            if (hdr2_tvalid) begin
                if (exp2_hdr.size() == 0) check_eq("w256_hdr_unexpected", exp2_hdr.size(), 1);
                else check_eq("w256_hdr", hdr2_tdata, exp2_hdr.pop_front());
            end
            if (py2_tvalid) begin
                if (exp2_py.size() == 0) check_eq("w256_pyld_unexpected", exp2_py.size(), 1);
                else check_eq("w256_pyld", {py2_tlast, py2_tdata}, exp2_py.pop_front());
            end
            if (md2_tvalid) check_eq("w256_mdata_unexpected", md2_tvalid, 0);
        end
    end

    task automatic drive_beat(input logic [W-1:0] dat, input logic last);
        int n;
        n = 0;
        s_tdata = dat; s_tlast = last; s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check_eq("drive_timeout", s_tready, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drive_beat2(input logic [W2-1:0] dat, input logic last);
        int n;
        n = 0;
        s2_tdata = dat; s2_tlast = last; s2_tvalid = 1'b1;
        @(negedge clk);
        while (!s2_tready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check_eq("w256_drive_timeout", s2_tready, 1);
        @(posedge clk); #1;
        s2_tvalid = 1'b0;
    endtask

    // Pushes expectations for a 64-bit packet, then drives it.
    task automatic send_pkt(input logic [2:0] pt, input logic [4:0] nm, input logic [15:0] len,
                            input logic [63:0] ts, input int n_md, input int n_py);
        logic [63:0] hh, dd;
        bit ts_beat;
        int beats;
        pkt_id++;
        hh = mk_hdr(pt, nm, len, 16'(pkt_id));
        ts_beat = (pt == 3'd7) && (n_md + n_py > 0);
        beats = 1 + int'(ts_beat) + n_md + n_py;
        exp_hdr.push_back({(pt == 3'd7), ts_beat ? ts : 64'd0, hh});
        if (beats != (int'(len) + 7) / 8 || (pt == 3'd7 && beats == 1)) exp_errs++;
        drive_beat(hh, beats == 1);
        if (ts_beat) drive_beat(ts, 1'b0);
        for (int i = 0; i < n_md; i++) begin
            dd = {8'hD0, 24'(pkt_id), 32'(i)};
            exp_md.push_back({(i == int'(nm) - 1) || (i == n_md - 1 && n_py == 0), dd});
            drive_beat(dd, i == n_md - 1 && n_py == 0);
        end
        for (int i = 0; i < n_py; i++) begin
            dd = {8'hE0, 24'(pkt_id), 32'(i)};
            exp_py.push_back({(i == n_py - 1), dd});
            drive_beat(dd, i == n_py - 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_hdr.size() + exp_md.size() + exp_py.size() + exp2_hdr.size()
                + exp2_py.size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        // Reset state, with a beat offered so tready/tvalid gating is exercised.
        s_tvalid = 1'b1;
        #12;
        check_eq("rst_s_tready", s_tready, 0);
        check_eq("rst_hdr_tvalid", hdr_tvalid, 0);
        check_eq("rst_mdata_tvalid", md_tvalid, 0);
        check_eq("rst_pyld_tvalid", py_tvalid, 0);
        check_eq("rst_err_length", err_len, 0);
        check_eq("rst_err_count", err_cnt, 0);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Short packet: length 40 but only three beats.
        send_pkt(3'd6, 5'd0, 16'd40, 64'd0, 0, 2);
        check_eq("len_err_pulse", err_len, LEN_EN);
        check_eq("len_err_count", err_cnt, LEN_EN ? 1 : 0);
        @(posedge clk); #1;
        check_eq("len_err_pulse_end", err_len, 0);
        drain();

        // Reset in the middle of a payload.
        pkt_id++;
        h = mk_hdr(3'd6, 5'd0, 16'd32, 16'(pkt_id));
        exp_hdr.push_back({1'b0, 64'd0, h});
        drive_beat(h, 1'b0);
        d = 64'hBEEF_0000_0000_0001;
        exp_py.push_back({1'b0, d});
        drive_beat(d, 1'b0);
        rst_n = 1'b0;
        s_tvalid = 1'b1;
        #1;
        check_eq("midrst_s_tready", s_tready, 0);
        check_eq("midrst_hdr_tvalid", hdr_tvalid, 0);
        check_eq("midrst_mdata_tvalid", md_tvalid, 0);
        check_eq("midrst_pyld_tvalid", py_tvalid, 0);
        check_eq("midrst_err_count", err_cnt, 0);
        exp_errs = 0;
        repeat (2) @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_pkt(3'd6, 5'd0, 16'd32, 64'd0, 0, 3);
        send_pkt(3'd7, 5'd2, 16'd48, 64'h0123_4567_89AB_CDEF, 2, 2);
        for (int k = 0; k < 4; k++) begin
            logic [2:0] pt;
            int nm, np, tsb;
            pt  = ($urandom_range(1) != 0) ? 3'd7 : 3'd6;
            nm  = $urandom_range(3);
            np  = $urandom_range(4, 1);
            tsb = (pt == 3'd7) ? 1 : 0;
            send_pkt(pt, 5'(nm), 16'(8 * (1 + tsb + nm + np)), {32'hA5A5_0000, 32'(k)}, nm, np);
        end
        drain();

        // Back-to-back packets while the header output is stalled.
        rand_bp = 1'b0;
        @(posedge clk); #1;
        hdr_stall = 5;
        hdr_tready = 1'b0;
        send_pkt(3'd6, 5'd0, 16'd16, 64'd0, 0, 1);
        s_tdata = mk_hdr(3'd6, 5'd0, 16'd24, 16'hFFFF);
        s_tvalid = 1'b1;
        @(negedge clk);
        check_eq("stall_s_tready", s_tready, 0);
        check_eq("stall_hdr_tvalid", hdr_tvalid, 1);
        send_pkt(3'd6, 5'd0, 16'd24, 64'd0, 0, 2);
        rand_bp = 1'b1;

        // Header-only timestamped packet, then metadata cut short by tlast.
        send_pkt(3'd7, 5'd0, 16'd16, 64'd0, 0, 0);
        send_pkt(3'd6, 5'd3, 16'd32, 64'd0, 2, 0);
        drain();
        check_eq("err_count_final", err_cnt, LEN_EN ? exp_errs : 0);

        // 256-bit instance: timestamp rides in the header beat.
        h = mk_hdr(3'd7, 5'd0, 16'd64, 16'h0100);
        beat2 = '0;
        beat2[63:0] = h;
        beat2[127:64] = 64'hDEAD;
        pl2 = {4{64'hCAFE_0000_1234_5678}};
        exp2_hdr.push_back({1'b1, 64'hDEAD, h});
        exp2_py.push_back({1'b1, pl2});
        drive_beat2(beat2, 1'b0);
        drive_beat2(pl2, 1'b1);
        drain();
        check_eq("w256_err_count", err2_cnt, 0);

        check_eq("left_hdr", exp_hdr.size(), 0);
        check_eq("left_mdata", exp_md.size(), 0);
        check_eq("left_pyld", exp_py.size(), 0);
        check_eq("left_w256", exp2_hdr.size() + exp2_py.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
